path_reader: RTL and testbench

PATH_READER -- requirements
Module: path_reader

---
 rtl/path_reader.sv | 181 ++++++++++++++++++
 tb/tb_path_reader.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/path_reader.sv
// path_reader: reads a DTW warping path back from SRAM after the core finishes.
// Word 0 carries the DTW distance and the first path point; each later word
// carries one more point. Points are streamed out over a valid/ready handshake
// until a (0,0) point or MAX_LEN words have been read.
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   start_i               one-cycle pulse that starts a readback run
//   rdata_i               SRAM read data, valid the cycle after a read is issued
//   addr_o, CS_o, WR_o    SRAM address, active-low chip select, write enable (tied 0)
//   out_valid_o/ready_i   point handshake
//   x_o, y_o, last_o      presented path point and end-of-run flag
//   dtw_o, dtw_valid_o    DTW distance latched from word 0
//   busy_o                run in progress
module path_reader #(
  parameter int unsigned DTW_W     = 12,
  parameter logic [9:0]  BASE_ADDR = 10'h014,
  parameter int unsigned MAX_LEN   = 63
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [31:0]      rdata_i,
  output logic [9:0]       addr_o,
  output logic             CS_o,
  output logic             WR_o,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [4:0]       x_o,
  output logic [4:0]       y_o,
  output logic             last_o,
  output logic [DTW_W-1:0] dtw_o,
  output logic             dtw_valid_o,
  output logic             busy_o
);

  localparam int unsigned ADDR_W = 10;
  localparam int unsigned K_W    = 6;
  localparam int unsigned CRD_W  = 5;

  // Read index of the final word a run may fetch.
  localparam logic [K_W-1:0] K_LAST = K_W'(MAX_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_CAPT    = 2'd2,
    S_PRESENT = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [K_W-1:0]      k_q, k_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                cs_q, cs_d;
  logic                valid_q, valid_d;
  logic [CRD_W-1:0]    x_q, x_d;
  logic [CRD_W-1:0]    y_q, y_d;
  logic                last_q, last_d;
  logic [DTW_W-1:0]    dtw_q, dtw_d;
  logic                dtw_valid_q, dtw_valid_d;
  logic                busy_q, busy_d;

  // Fields of the word currently on rdata_i.
  logic [CRD_W-1:0]    rd_x;
  logic [CRD_W-1:0]    rd_y;
  logic [DTW_W-1:0]    rd_dtw;
  logic                unused_rdata;

  assign rd_x         = rdata_i[20:16];
  assign rd_y         = rdata_i[28:24];
  assign rd_dtw       = rdata_i[DTW_W-1:0];
  assign unused_rdata = ^rdata_i;

  // Next-state and next-output logic. Outputs are computed for the state being
  // entered so every port comes straight from a flop.
  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    addr_d      = BASE_ADDR;
    cs_d        = 1'b1;
    valid_d     = 1'b0;
    x_d         = x_q;
    y_d         = y_q;
    last_d      = last_q;
    dtw_d       = dtw_q;
    dtw_valid_d = dtw_valid_q;
    busy_d      = busy_q;

    unique case (state_q)
      S_IDLE: begin
        k_d    = '0;
        busy_d = 1'b0;
        if (start_i) begin
          state_d     = S_ISSUE;
          dtw_valid_d = 1'b0;
          busy_d      = 1'b1;
          addr_d      = BASE_ADDR;
          cs_d        = 1'b0;
        end
      end

      S_ISSUE: begin
        state_d = S_CAPT;
      end

      S_CAPT: begin
        state_d = S_PRESENT;
        valid_d = 1'b1;
        x_d     = rd_x;
        y_d     = rd_y;
        last_d  = ((rd_x == '0) && (rd_y == '0)) || (k_q == K_LAST);
        if (k_q == '0) begin
          dtw_d       = rd_dtw;
          dtw_valid_d = 1'b1;
        end
      end

      S_PRESENT: begin
        valid_d = 1'b1;
        if (out_ready_i) begin
          valid_d = 1'b0;
          if (last_q) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
          end else begin
            // k never wraps: last_q is forced at K_LAST.
            k_d     = k_q + K_W'(1);
            state_d = S_ISSUE;
            addr_d  = BASE_ADDR + ADDR_W'(k_q + K_W'(1));
            cs_d    = 1'b0;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      k_q         <= '0;
      addr_q      <= BASE_ADDR;
      cs_q        <= 1'b1;
      valid_q     <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      last_q      <= 1'b0;
      dtw_q       <= '0;
      dtw_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      addr_q      <= addr_d;
      cs_q        <= cs_d;
      valid_q     <= valid_d;
      x_q         <= x_d;
      y_q         <= y_d;
      last_q      <= last_d;
      dtw_q       <= dtw_d;
      dtw_valid_q <= dtw_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign addr_o      = addr_q;
  assign CS_o        = cs_q;
  assign WR_o        = 1'b0;
  assign out_valid_o = valid_q;
  assign x_o         = x_q;
  assign y_o         = y_q;
  assign last_o      = last_q;
  assign dtw_o       = dtw_q;
  assign dtw_valid_o = dtw_valid_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_path_reader.sv
// Bench for path_reader: SRAM model, scoreboard of expected points per run.
module tb_path_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start_a, start_b, ready_a, ready_b;
  logic [31:0] rdata_a = '0, rdata_b = '0;
  logic [9:0]  addr_a, addr_b;
  logic        cs_a, cs_b, wr_a, wr_b, valid_a, valid_b, last_a, last_b;
  logic [4:0]  x_a, y_a, x_b, y_b;
  logic [11:0] dtw_a, dtw_b;
  logic        dtwv_a, dtwv_b, busy_a, busy_b;

  path_reader dut_a (
    .clk_i(clk), .rst_i(rst), .start_i(start_a), .rdata_i(rdata_a),
    .addr_o(addr_a), .CS_o(cs_a), .WR_o(wr_a), .out_valid_o(valid_a),
    .out_ready_i(ready_a), .x_o(x_a), .y_o(y_a), .last_o(last_a),
    .dtw_o(dtw_a), .dtw_valid_o(dtwv_a), .busy_o(busy_a)
  );

  path_reader #(.MAX_LEN(4)) dut_b (
    .clk_i(clk), .rst_i(rst), .start_i(start_b), .rdata_i(rdata_b),
    .addr_o(addr_b), .CS_o(cs_b), .WR_o(wr_b), .out_valid_o(valid_b),
    .out_ready_i(ready_b), .x_o(x_b), .y_o(y_b), .last_o(last_b),
    .dtw_o(dtw_b), .dtw_valid_o(dtwv_b), .busy_o(busy_b)
  );

  logic [31:0] mem [0:1023];
  logic [9:0]  alog_a[$];
  logic [9:0]  alog_b[$];
  logic [10:0] exp_q[$];
  int checks = 0;
  int passed = 0;

  localparam logic [37:0] RST_VEC = {10'h014, 1'b1, 1'b0, 1'b0, 1'b0,
                                     5'd0, 5'd0, 12'd0, 1'b0, 1'b0};

  // SRAM models: one-cycle read latency, log of every issued address.
  always @(posedge clk) begin
    if (!cs_a) begin
      rdata_a <= mem[addr_a];
      alog_a.push_back(addr_a);
    end
    if (!cs_b) begin
      rdata_b <= mem[addr_b];
      alog_b.push_back(addr_b);
    end
  end

  // Word with junk in the ignored bit positions.
  function automatic logic [31:0] mkw(input logic [4:0] y, input logic [4:0] x,
                                      input logic [11:0] d);
    return {3'b101, y, 3'b110, x, 4'hA, d};
  endfunction

  task automatic load_basic();
    mem[10'h014] = mkw(5'd3, 5'd3, 12'h05A);
    mem[10'h015] = mkw(5'd2, 5'd2, 12'hF00);
    mem[10'h016] = mkw(5'd1, 5'd1, 12'h777);
    mem[10'h017] = mkw(5'd0, 5'd0, 12'h123);
  endtask

  task automatic push_basic();
    exp_q.delete();
    exp_q.push_back({5'd3, 5'd3, 1'b0});
    exp_q.push_back({5'd2, 5'd2, 1'b0});
    exp_q.push_back({5'd1, 5'd1, 1'b0});
    exp_q.push_back({5'd0, 5'd0, 1'b1});
  endtask

  task automatic test_reset();
    rst = 1'b1; start_a = 1'b1; start_b = 1'b1;
    @(negedge clk);
    start_a = 1'b0; start_b = 1'b0;
    checks++;
    if ({addr_a, cs_a, wr_a, valid_a, last_a, x_a, y_a, dtw_a, dtwv_a, busy_a} !== RST_VEC)
      $display("FAIL reset_a got=%h want=%h",
               {addr_a, cs_a, wr_a, valid_a, last_a, x_a, y_a, dtw_a, dtwv_a, busy_a}, RST_VEC);
    else passed++;
    checks++;
    if ({addr_b, cs_b, wr_b, valid_b, last_b, x_b, y_b, dtw_b, dtwv_b, busy_b} !== RST_VEC)
      $display("FAIL reset_b got=%h want=%h",
               {addr_b, cs_b, wr_b, valid_b, last_b, x_b, y_b, dtw_b, dtwv_b, busy_b}, RST_VEC);
    else passed++;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy_a, cs_a} !== 2'b01)
      $display("FAIL reset_prio busy,cs got=%b want=01", {busy_a, cs_a});
    else passed++;
  endtask

  task automatic test_basic();
    int cyc, first, lastc, npts;
    logic [10:0] e;
    bit done;
    load_basic(); push_basic(); alog_a.delete();
    ready_a = 1'b1;
    start_a = 1'b1; @(negedge clk); start_a = 1'b0;
    cyc = 1; first = -1; lastc = -1; npts = 0; done = 0;
    checks++;
    if (busy_a !== 1'b1) $display("FAIL basic_busy got=%b want=1", busy_a); else passed++;
    while (!done && cyc < 60) begin
      if (valid_a) begin
        if (first < 0) begin
          first = cyc;
          checks++;
          if (first != 3) $display("FAIL basic_latency got=%0d want=3", first); else passed++;
          checks++;
          if ({dtwv_a, dtw_a} !== {1'b1, 12'h05A})
            $display("FAIL basic_dtw got=%b/%h want=1/05a", dtwv_a, dtw_a);
          else passed++;
        end
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 11'h7FF;
        checks++;
        if ({x_a, y_a, last_a} !== e)
          $display("FAIL basic_point got=%h want=%h", {x_a, y_a, last_a}, e);
        else passed++;
        npts++; lastc = cyc;
        if (last_a) done = 1;
      end
      @(negedge clk); cyc++;
    end
    checks++;
    if (!done || npts != 4 || lastc != 12)
      $display("FAIL basic_count done=%0d pts=%0d lastcyc=%0d want 1/4/12", done, npts, lastc);
    else passed++;
    checks++;
    if ({busy_a, valid_a, dtwv_a, dtw_a} !== {1'b0, 1'b0, 1'b1, 12'h05A})
      $display("FAIL basic_end got=%h want=%h", {busy_a, valid_a, dtwv_a, dtw_a},
               {1'b0, 1'b0, 1'b1, 12'h05A});
    else passed++;
    checks++;
    if (alog_a.size() != 4) $display("FAIL basic_nreads got=%0d want=4", alog_a.size());
    else passed++;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (alog_a[i] !== 10'(10'h014 + i))
        $display("FAIL basic_addr%0d got=%h want=%h", i, alog_a[i], 10'(10'h014 + i));
      else passed++;
    end
  endtask

  task automatic test_stall();
    int cyc, stall, npts;
    logic [10:0] e;
    bit done;
    load_basic(); push_basic(); alog_a.delete();
    ready_a = 1'b1;
    start_a = 1'b1; @(negedge clk); start_a = 1'b0;
    cyc = 1; stall = 0; npts = 0; done = 0;
    while (!done && cyc < 80) begin
      if (valid_a) begin
        if (x_a == 5'd2 && stall < 5) begin
          ready_a = 1'b0; stall++;
          checks++;
          if ({valid_a, x_a, y_a, last_a} !== {1'b1, 5'd2, 5'd2, 1'b0})
            $display("FAIL stall_hold got=%h want=%h", {valid_a, x_a, y_a, last_a},
                     {1'b1, 5'd2, 5'd2, 1'b0});
          else passed++;
          checks++;
          if (alog_a.size() != 2 || cs_a !== 1'b1)
            $display("FAIL stall_noread reads=%0d cs=%b want 2/1", alog_a.size(), cs_a);
          else passed++;
        end else begin
          ready_a = 1'b1;
          e = (exp_q.size() > 0) ? exp_q.pop_front() : 11'h7FF;
          checks++;
          if ({x_a, y_a, last_a} !== e)
            $display("FAIL stall_point got=%h want=%h", {x_a, y_a, last_a}, e);
          else passed++;
          npts++;
          if (last_a) done = 1;
        end
      end else ready_a = 1'b1;
      @(negedge clk); cyc++;
    end
    ready_a = 1'b1;
    checks++;
    if (!done || npts != 4 || stall != 5 || cyc != 18)
      $display("FAIL stall_count done=%0d pts=%0d stall=%0d cyc=%0d want 1/4/5/18",
               done, npts, stall, cyc);
    else passed++;
    checks++;
    if (alog_a.size() != 4 || alog_a[2] !== 10'h016)
      $display("FAIL stall_addr n=%0d a2=%h want 4/016", alog_a.size(), alog_a[2]);
    else passed++;
  endtask

  task automatic test_max_len();
    int cyc, npts;
    logic [10:0] e;
    bit done;
    exp_q.delete(); alog_b.delete();
    for (int i = 0; i < 5; i++) begin
      mem[10'(10'h014 + i)] = mkw(5'(i + 5), 5'(i + 1), 12'(i + 7));
      exp_q.push_back({5'(i + 1), 5'(i + 5), (i == 3)});
    end
    void'(exp_q.pop_back());
    ready_b = 1'b1;
    start_b = 1'b1; @(negedge clk); start_b = 1'b0;
    cyc = 1; npts = 0; done = 0;
    while (!done && cyc < 60) begin
      if (valid_b) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 11'h7FF;
        checks++;
        if ({x_b, y_b, last_b} !== e)
          $display("FAIL maxlen_point got=%h want=%h", {x_b, y_b, last_b}, e);
        else passed++;
        npts++;
        if (last_b) done = 1;
      end
      @(negedge clk); cyc++;
    end
    repeat (4) @(negedge clk);
    checks++;
    if (!done || npts != 4 || busy_b !== 1'b0 || dtw_b !== 12'h007)
      $display("FAIL maxlen_count done=%0d pts=%0d busy=%b dtw=%h want 1/4/0/007",
               done, npts, busy_b, dtw_b);
    else passed++;
    checks++;
    if (alog_b.size() != 4 || alog_b[alog_b.size() - 1] !== 10'h017)
      $display("FAIL maxlen_addr n=%0d final=%h want 4/017", alog_b.size(),
               alog_b[alog_b.size() - 1]);
    else passed++;
  endtask

  task automatic test_reset_mid();
    int cyc, npts;
    logic [10:0] e;
    bit done;
    load_basic(); alog_a.delete();
    ready_a = 1'b1;
    start_a = 1'b1; @(negedge clk); start_a = 1'b0;
    cyc = 1;
    while (!valid_a && cyc < 20) begin @(negedge clk); cyc++; end
    checks++;
    if ({valid_a, x_a, y_a, last_a} !== {1'b1, 5'd3, 5'd3, 1'b0})
      $display("FAIL rstmid_first got=%h want=%h", {valid_a, x_a, y_a, last_a},
               {1'b1, 5'd3, 5'd3, 1'b0});
    else passed++;
    @(negedge clk);
    checks++;
    if ({cs_a, addr_a} !== {1'b0, 10'h015})
      $display("FAIL rstmid_issue got=%h want=%h", {cs_a, addr_a}, {1'b0, 10'h015});
    else passed++;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({addr_a, cs_a, wr_a, valid_a, last_a, x_a, y_a, dtw_a, dtwv_a, busy_a} !== RST_VEC)
      $display("FAIL rstmid_state got=%h want=%h",
               {addr_a, cs_a, wr_a, valid_a, last_a, x_a, y_a, dtw_a, dtwv_a, busy_a}, RST_VEC);
    else passed++;
    repeat (5) @(negedge clk);
    checks++;
    if (alog_a.size() != 2 || valid_a !== 1'b0 || busy_a !== 1'b0)
      $display("FAIL rstmid_quiet reads=%0d valid=%b busy=%b want 2/0/0",
               alog_a.size(), valid_a, busy_a);
    else passed++;
    push_basic(); alog_a.delete();
    start_a = 1'b1; @(negedge clk); start_a = 1'b0;
    cyc = 1; npts = 0; done = 0;
    while (!done && cyc < 60) begin
      if (valid_a) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 11'h7FF;
        checks++;
        if ({x_a, y_a, last_a} !== e)
          $display("FAIL rstmid_point got=%h want=%h", {x_a, y_a, last_a}, e);
        else passed++;
        npts++;
        if (last_a) done = 1;
      end
      @(negedge clk); cyc++;
    end
    checks++;
    if (!done || npts != 4 || alog_a.size() != 4 || alog_a[0] !== 10'h014)
      $display("FAIL rstmid_rerun done=%0d pts=%0d reads=%0d a0=%h want 1/4/4/014",
               done, npts, alog_a.size(), alog_a[0]);
    else passed++;
  endtask

  task automatic test_start_busy();
    int cyc, npts, lastc;
    logic [10:0] e;
    bit done;
    load_basic(); push_basic(); alog_a.delete();
    ready_a = 1'b1;
    start_a = 1'b1; @(negedge clk); start_a = 1'b0;
    cyc = 1; npts = 0; lastc = -1; done = 0;
    while (!done && cyc < 60) begin
      start_a = (cyc == 4 || cyc == 8) ? 1'b1 : 1'b0;
      if (cyc == 4) begin
        checks++;
        if (busy_a !== 1'b1) $display("FAIL busystart_busy got=%b want=1", busy_a);
        else passed++;
      end
      if (valid_a) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 11'h7FF;
        checks++;
        if ({x_a, y_a, last_a} !== e)
          $display("FAIL busystart_point got=%h want=%h", {x_a, y_a, last_a}, e);
        else passed++;
        npts++; lastc = cyc;
        if (last_a) done = 1;
      end
      @(negedge clk); cyc++;
    end
    start_a = 1'b0;
    checks++;
    if (!done || npts != 4 || lastc != 12 || alog_a.size() != 4)
      $display("FAIL busystart_seq done=%0d pts=%0d lastcyc=%0d reads=%0d want 1/4/12/4",
               done, npts, lastc, alog_a.size());
    else passed++;
    // Single-point run whose first word is (0,0).
    mem[10'h014] = mkw(5'd0, 5'd0, 12'h3FF);
    exp_q.delete(); exp_q.push_back({5'd0, 5'd0, 1'b1}); alog_a.delete();
    @(negedge clk);
    start_a = 1'b1; @(negedge clk); start_a = 1'b0;
    checks++;
    if ({busy_a, dtwv_a} !== 2'b10)
      $display("FAIL single_clear busy,dtwv got=%b want=10", {busy_a, dtwv_a});
    else passed++;
    cyc = 1; npts = 0; done = 0;
    while (!done && cyc < 30) begin
      if (valid_a) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 11'h7FF;
        checks++;
        if ({x_a, y_a, last_a, dtwv_a, dtw_a} !== {e, 1'b1, 12'h3FF})
          $display("FAIL single_point got=%h want=%h", {x_a, y_a, last_a, dtwv_a, dtw_a},
                   {e, 1'b1, 12'h3FF});
        else passed++;
        npts++;
        if (last_a) done = 1;
      end
      @(negedge clk); cyc++;
    end
    repeat (4) @(negedge clk);
    checks++;
    if (!done || npts != 1 || alog_a.size() != 1 || {busy_a, dtwv_a, dtw_a} !== {2'b01, 12'h3FF})
      $display("FAIL single_end done=%0d pts=%0d reads=%0d busy,dtwv,dtw=%h want 1/1/1/%h",
               done, npts, alog_a.size(), {busy_a, dtwv_a, dtw_a}, {2'b01, 12'h3FF});
    else passed++;
  endtask

  initial begin
    rst = 1'b1; start_a = 1'b0; start_b = 1'b0; ready_a = 1'b1; ready_b = 1'b1;
    repeat (2) @(negedge clk);
    test_reset();
    test_basic();
    test_stall();
    test_max_len();
    test_reset_mid();
    test_start_busy();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
